// File: rtl/block_ram_arbiter.sv
// ---------------------------------------------------------------------------
// block_ram_arbiter
//
// Purpose:
//   Shares one single-port block RAM between two requesters (port 0, port 1).
//   Arbitration is round-robin, with an optional lock that lets one port keep
//   the RAM for back-to-back bursts. The RAM's one-cycle read latency is
//   tracked so that each response goes back to the port that issued it.
//
// Ports:
//   i_clk         clock, all state changes on the rising edge
//   i_rst         asynchronous active-high reset
//   i_p_req[i]    port i requests an access this cycle
//   i_p_lock[i]   port i wants to keep the grant after this access
//   i_p_we[i]     port i per-byte write enable (all zero = read)
//   i_p_addr[i]   port i word address
//   i_p_wdata[i]  port i write data
//   o_p_ready[i]  port i request accepted this cycle (combinational)
//   o_p_rvalid[i] port i response, one cycle after its acceptance
//   o_p_rdata[i]  port i read data, valid while o_p_rvalid[i]
//   o_ram_we      RAM per-byte write enable
//   o_ram_addr    RAM address
//   o_ram_wdata   RAM write data
//   i_ram_rdata   RAM read data, one-cycle latency
// ---------------------------------------------------------------------------
module block_ram_arbiter #(
    parameter  int abits  = 8,
    parameter  int dbytes = 4,
    parameter  int blen   = 8,
    localparam int dbits  = dbytes * blen
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_p_req,
    input  logic [1:0]        i_p_lock,
    input  logic [dbytes-1:0] i_p_we    [2],
    input  logic [abits-1:0]  i_p_addr  [2],
    input  logic [dbits-1:0]  i_p_wdata [2],
    output logic [1:0]        o_p_ready,
    output logic [1:0]        o_p_rvalid,
    output logic [dbits-1:0]  o_p_rdata [2],
    output logic [dbytes-1:0] o_ram_we,
    output logic [abits-1:0]  o_ram_addr,
    output logic [dbits-1:0]  o_ram_wdata,
    input  logic [dbits-1:0]  i_ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t r_state;
    logic   r_prio;
    logic   r_rsp_v;
    logic   r_rsp_id;

    state_t w_state_next;
    logic   w_prio_next;
    logic   w_grant_v;
    logic   w_grant_id;
    logic   w_sel;

    // Next-state, priority update and grant decision.
    always_comb begin
        w_state_next = r_state;
        w_prio_next  = r_prio;
        w_grant_v    = 1'b0;
        w_grant_id   = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_p_req == 2'b11) begin
                    // Contention: the priority port wins and loses priority.
                    w_grant_v   = 1'b1;
                    w_grant_id  = r_prio;
                    w_prio_next = ~r_prio;
                end else if (i_p_req[0]) begin
                    w_grant_v  = 1'b1;
                    w_grant_id = 1'b0;
                end else if (i_p_req[1]) begin
                    w_grant_v  = 1'b1;
                    w_grant_id = 1'b1;
                end
                if (w_grant_v && i_p_lock[w_grant_id]) begin
                    w_state_next = w_grant_id ? LOCK1 : LOCK0;
                end
            end
            LOCK0: begin
                // The owner keeps the RAM; idle cycles do not release it.
                if (i_p_req[0]) begin
                    w_grant_v  = 1'b1;
                    w_grant_id = 1'b0;
                    if (!i_p_lock[0]) begin
                        w_state_next = IDLE;
                        w_prio_next  = 1'b1;
                    end
                end
            end
            LOCK1: begin
                if (i_p_req[1]) begin
                    w_grant_v  = 1'b1;
                    w_grant_id = 1'b1;
                    if (!i_p_lock[1]) begin
                        w_state_next = IDLE;
                        w_prio_next  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // No transfer may be accepted while reset is held.
        if (i_rst) begin
            w_grant_v = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_prio   <= 1'b0;
            r_rsp_v  <= 1'b0;
            r_rsp_id <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_prio  <= w_prio_next;
            r_rsp_v <= w_grant_v;
            if (w_grant_v) begin
                r_rsp_id <= w_grant_id;
            end
        end
    end

    // RAM mux: with no grant the port-0 address/data pass through but the
    // write enable is forced off.
    assign w_sel       = w_grant_v & w_grant_id;
    assign o_ram_we    = w_grant_v ? i_p_we[w_grant_id] : '0;
    assign o_ram_addr  = i_p_addr[w_sel];
    assign o_ram_wdata = i_p_wdata[w_sel];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign o_p_ready[gi]  = w_grant_v && (w_grant_id == 1'(gi));
            assign o_p_rvalid[gi] = r_rsp_v && (r_rsp_id == 1'(gi));
            assign o_p_rdata[gi]  = i_ram_rdata;
        end
    endgenerate

endmodule
